// File: rtl/exec_core_np_pkg.sv
// Shared definitions for the parametrised execute core: instruction field
// layout, opcode/sub-op encodings, FSM state encodings and a field splitter.
package exec_core_np_pkg;

    localparam int unsigned INSN_W = 32;
    localparam int unsigned RIDX_W = 5;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned SUB_W  = 5;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DEC  = 2'd1;
    localparam logic [1:0] ST_EXE  = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    // Major opcodes, ir[30:25]
    localparam logic [OP_W-1:0] OP_ADDI = 6'b101000;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b101100;
    localparam logic [OP_W-1:0] OP_XORI = 6'b101011;
    localparam logic [OP_W-1:0] OP_MOVI = 6'b100010;
    localparam logic [OP_W-1:0] OP_ALU  = 6'b100000;

    // ALU sub-ops, ir[4:0]
    localparam logic [SUB_W-1:0] SUB_ADD   = 5'b00000;
    localparam logic [SUB_W-1:0] SUB_SUB   = 5'b00001;
    localparam logic [SUB_W-1:0] SUB_AND   = 5'b00010;
    localparam logic [SUB_W-1:0] SUB_XOR   = 5'b00011;
    localparam logic [SUB_W-1:0] SUB_OR    = 5'b00100;
    localparam logic [SUB_W-1:0] SUB_SLLI  = 5'b01000;
    localparam logic [SUB_W-1:0] SUB_SRLI  = 5'b01001;
    localparam logic [SUB_W-1:0] SUB_SRAI  = 5'b01010;
    localparam logic [SUB_W-1:0] SUB_ROTRI = 5'b01011;

    // Decoded instruction fields; rb doubles as imm5 for the shift sub-ops
    typedef struct packed {
        logic                    bad_fmt;
        logic [OP_W-1:0]         op;
        logic [RIDX_W-1:0]       rt;
        logic [RIDX_W-1:0]       ra;
        logic [RIDX_W-1:0]       rb;
        logic [SUB_W-1:0]        sub;
        logic [14:0]             imm15;
        logic [19:0]             imm20;
    } insn_t;

    function automatic insn_t split_insn(input logic [INSN_W-1:0] w);
        insn_t f;
        f.bad_fmt = w[31];
        f.op      = w[30:25];
        f.rt      = w[24:20];
        f.ra      = w[19:15];
        f.rb      = w[14:10];
        f.sub     = w[4:0];
        f.imm15   = w[14:0];
        f.imm20   = w[19:0];
        return f;
    endfunction

endpackage

// File: rtl/exec_core_np_if.sv
// Instruction handshake and completion status between issuer and execute core.
//  instruction/in_valid : issuer -> core
//  in_ready             : core accepts this cycle
//  done/illegal         : completion pulse and its illegal-instruction flag
interface exec_core_np_if;
    logic [exec_core_np_pkg::INSN_W-1:0] instruction;
    logic                                in_valid;
    logic                                in_ready;
    logic                                done;
    logic                                illegal;

    modport master (output instruction, in_valid, input in_ready, done, illegal);
    modport slave  (input instruction, in_valid, output in_ready, done, illegal);
endinterface

// File: rtl/regfile_np.sv
// Register file: two async operand read ports, one async debug read port and
// one synchronous write port. Out-of-range indices read as zero, writes to
// them are dropped. Synchronous active-high reset clears every entry.
//  clk, reset                 : clock, sync reset
//  ra_addr/ra_data            : operand A read
//  rb_addr/rb_data            : operand B read
//  dbg_addr/dbg_data          : debug read
//  we, wr_addr, wr_data       : write port
module regfile_np #(
    parameter int unsigned DataSize = 32,
    parameter int unsigned RegNum   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          ra_addr,
    output logic [DataSize-1:0] ra_data,
    input  logic [4:0]          rb_addr,
    output logic [DataSize-1:0] rb_data,
    input  logic [4:0]          dbg_addr,
    output logic [DataSize-1:0] dbg_data,
    input  logic                we,
    input  logic [4:0]          wr_addr,
    input  logic [DataSize-1:0] wr_data
);

    localparam int unsigned AW = (RegNum > 1) ? $clog2(RegNum) : 1;

    logic [DataSize-1:0] regs [RegNum];

    assign ra_data  = (32'(ra_addr)  < RegNum) ? regs[ra_addr[AW-1:0]]  : '0;
    assign rb_data  = (32'(rb_addr)  < RegNum) ? regs[rb_addr[AW-1:0]]  : '0;
    assign dbg_data = (32'(dbg_addr) < RegNum) ? regs[dbg_addr[AW-1:0]] : '0;

    // Storage update; reset has priority over a coincident write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(RegNum); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (32'(wr_addr) < RegNum)) begin
            regs[wr_addr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/exec_core_np.sv
// Multi-cycle execute core: IDLE -> DEC -> EXE -> WB, one instruction per
// four cycles. Operands are latched in DEC, the result in EXE, and the
// register file is written on the edge that leaves WB.
//  clk, reset          : clock, synchronous active-high reset
//  bus (slave)         : instruction handshake, done pulse, illegal flag
//  dbg_addr/dbg_data   : combinational register read, 0 when out of range
module exec_core_np
    import exec_core_np_pkg::*;
#(
    parameter int unsigned DataSize = 32,
    parameter int unsigned RegNum   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    exec_core_np_if.slave        bus,
    input  logic [4:0]           dbg_addr,
    output logic [DataSize-1:0]  dbg_data
);

    logic [1:0]          state;
    logic [1:0]          state_nx;
    logic [INSN_W-1:0]   ir;
    insn_t               f_c;
    logic [DataSize-1:0] op_a;
    logic [DataSize-1:0] op_b;
    logic [DataSize-1:0] res;
    logic [DataSize-1:0] ra_data_c;
    logic [DataSize-1:0] rb_data_c;
    logic [DataSize-1:0] alu_c;
    logic                illegal_c;
    logic                illegal_q;
    logic                done_q;
    logic                known_c;
    logic                uses_ra_c;
    logic                uses_rb_c;

    assign f_c          = split_insn(ir);
    assign bus.in_ready = (state == ST_IDLE) & ~reset;
    assign bus.done     = done_q;
    assign bus.illegal  = illegal_q;

    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < RegNum;
    endfunction

    // State register; done is registered from the next state so it lines up with WB
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= (state_nx == ST_WB);
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_nx = ST_DEC;
            ST_DEC:  state_nx = ST_EXE;
            ST_EXE:  state_nx = ST_WB;
            ST_WB:   state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Legality decode: which register fields are actually used per opcode
    always_comb begin
        known_c   = 1'b0;
        uses_ra_c = 1'b1;
        uses_rb_c = 1'b0;
        case (f_c.op)
            OP_ADDI, OP_ORI, OP_XORI: known_c = 1'b1;
            OP_MOVI: begin
                known_c   = 1'b1;
                uses_ra_c = 1'b0;
            end
            OP_ALU: begin
                case (f_c.sub)
                    SUB_ADD, SUB_SUB, SUB_AND, SUB_XOR, SUB_OR: begin
                        known_c   = 1'b1;
                        uses_rb_c = 1'b1;
                    end
                    SUB_SLLI, SUB_SRLI, SUB_SRAI, SUB_ROTRI: known_c = 1'b1;
                    default: known_c = 1'b0;
                endcase
            end
            default: known_c = 1'b0;
        endcase
        illegal_c = f_c.bad_fmt | ~known_c | ~idx_ok(f_c.rt)
                  | (uses_ra_c & ~idx_ok(f_c.ra))
                  | (uses_rb_c & ~idx_ok(f_c.rb));
    end

    // Execute; rb field is the 5-bit shift amount for shift/rotate sub-ops
    always_comb begin
        alu_c = '0;
        case (f_c.op)
            OP_ADDI: alu_c = op_a + {{(DataSize-15){f_c.imm15[14]}}, f_c.imm15};
            OP_ORI:  alu_c = op_a | DataSize'(f_c.imm15);
            OP_XORI: alu_c = op_a ^ DataSize'(f_c.imm15);
            OP_MOVI: alu_c = {{(DataSize-20){f_c.imm20[19]}}, f_c.imm20};
            OP_ALU: begin
                case (f_c.sub)
                    SUB_ADD:   alu_c = op_a + op_b;
                    SUB_SUB:   alu_c = op_a - op_b;
                    SUB_AND:   alu_c = op_a & op_b;
                    SUB_XOR:   alu_c = op_a ^ op_b;
                    SUB_OR:    alu_c = op_a | op_b;
                    SUB_SLLI:  alu_c = op_a << f_c.rb;
                    SUB_SRLI:  alu_c = op_a >> f_c.rb;
                    SUB_SRAI:  alu_c = DataSize'($signed(op_a) >>> f_c.rb);
                    // A zero amount shifts left by the full width, yielding 0, so op_a passes through
                    SUB_ROTRI: alu_c = (op_a >> f_c.rb) | (op_a << (DataSize - 32'(f_c.rb)));
                    default:   alu_c = '0;
                endcase
            end
            default: alu_c = '0;
        endcase
    end

    // Datapath registers: ir on accept, operands and flag in DEC, result in EXE
    always_ff @(posedge clk) begin
        if (reset) begin
            ir        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) ir <= bus.instruction;
                ST_DEC: begin
                    op_a      <= ra_data_c;
                    op_b      <= rb_data_c;
                    illegal_q <= illegal_c;
                end
                ST_EXE:  res <= alu_c;
                default: ;
            endcase
        end
    end

    regfile_np #(
        .DataSize (DataSize),
        .RegNum   (RegNum)
    ) u_rf (
        .clk      (clk),
        .reset    (reset),
        .ra_addr  (f_c.ra),
        .ra_data  (ra_data_c),
        .rb_addr  (f_c.rb),
        .rb_data  (rb_data_c),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       ((state == ST_WB) & ~illegal_q),
        .wr_addr  (f_c.rt),
        .wr_data  (res)
    );

endmodule
